// File: rtl/riscv_mem_arbiter_if.sv
// riscv_mem_arbiter_if: bundles the fetch, LSU and memory-side signals of the
// memory arbiter.
//   Fetch port : instr_req_i, instr_addr_i -> instr_gnt_o, instr_rvalid_o, instr_rdata_o
//   LSU port   : data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i
//                -> data_gnt_o, data_rvalid_o, data_rdata_o
//   Memory port: mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
//                <- mem_gnt_i, mem_rvalid_i, mem_rdata_i
//   Status     : arb_err_o
// Modports: slave is the arbiter's view; master is the view of the
// environment that drives the requests and models the memory.
interface riscv_mem_arbiter_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BeW = DATA_WIDTH / 8;

  logic                  instr_req_i;
  logic [ADDR_W-1:0]     instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [DATA_WIDTH-1:0] instr_rdata_o;

  logic                  data_req_i;
  logic                  data_we_i;
  logic [BeW-1:0]        data_be_i;
  logic [ADDR_W-1:0]     data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;

  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [BeW-1:0]        mem_be_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_gnt_i;
  logic                  mem_rvalid_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic                  arb_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output arb_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  arb_err_o
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one memory port between instruction fetch and the
// LSU, with at most one outstanding memory transaction.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; all outputs read 0 while held
//   bus  - riscv_mem_arbiter_if.slave (fetch, LSU and memory ports, arb_err_o)
// Arbitration in IDLE is decided combinationally in the request cycle.
// Configuration macro RISCV_MEM_ARB_RR_EN:
//   defined   - round-robin on contention (requester other than last_owner wins)
//   undefined - fixed priority, data over instr
// arb_err_o pulses one cycle after a mem_rvalid_i that arrives outside
// WAIT_RVALID; such responses are dropped.
module riscv_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  riscv_mem_arbiter_if.slave bus
);
  localparam int unsigned BeW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRvalid} state_e;
  typedef enum logic {OwnInstr, OwnData} owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   arb_err_q, arb_err_d;
`ifdef RISCV_MEM_ARB_RR_EN
  owner_e last_owner_q, last_owner_d;
`endif

  owner_e                winner;
  owner_e                sel;
  logic                  any_req;
  logic                  rsp_valid;
  logic                  mem_req;
  logic                  mem_we;
  logic [BeW-1:0]        mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  instr_gnt, data_gnt;
  logic                  instr_rvalid, data_rvalid;
  logic [DATA_WIDTH-1:0] instr_rdata, data_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnInstr;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      arb_err_q <= arb_err_d;
    end
  end

`ifdef RISCV_MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_q <= OwnInstr;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    arb_err_d = 1'b0;
    rsp_valid = 1'b0;
    mem_req   = 1'b0;
    any_req   = bus.instr_req_i | bus.data_req_i;

`ifdef RISCV_MEM_ARB_RR_EN
    // last_owner resets to instr, so the first contention goes to data.
    if (bus.instr_req_i && bus.data_req_i) begin
      winner = (last_owner_q == OwnData) ? OwnInstr : OwnData;
    end else begin
      winner = bus.data_req_i ? OwnData : OwnInstr;
    end
`else
    winner = bus.data_req_i ? OwnData : OwnInstr;
`endif

    // Once past IDLE the owner is locked; the other requester is ignored.
    sel = (state_q == StIdle) ? winner : owner_q;

    case (state_q)
      StIdle: begin
        mem_req = any_req;
        if (any_req) begin
          owner_d = winner;
          state_d = bus.mem_gnt_i ? StWaitRvalid : StWaitGnt;
        end
        arb_err_d = bus.mem_rvalid_i;
      end
      StWaitGnt: begin
        mem_req = 1'b1;
        if (bus.mem_gnt_i) begin
          state_d = StWaitRvalid;
        end
        arb_err_d = bus.mem_rvalid_i;
      end
      StWaitRvalid: begin
        if (bus.mem_rvalid_i) begin
          rsp_valid = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Request field mux; fetches are always full-word reads.
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      if (sel == OwnData) begin
        mem_we    = bus.data_we_i;
        mem_be    = bus.data_be_i;
        mem_addr  = bus.data_addr_i;
        mem_wdata = bus.data_wdata_i;
      end else begin
        mem_be    = {BeW{1'b1}};
        mem_addr  = bus.instr_addr_i;
      end
    end

    instr_gnt = mem_req & bus.mem_gnt_i & (sel == OwnInstr);
    data_gnt  = mem_req & bus.mem_gnt_i & (sel == OwnData);

    instr_rvalid = rsp_valid & (owner_q == OwnInstr);
    data_rvalid  = rsp_valid & (owner_q == OwnData);
    instr_rdata  = instr_rvalid ? bus.mem_rdata_i : '0;
    data_rdata   = data_rvalid ? bus.mem_rdata_i : '0;

`ifdef RISCV_MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
    if (mem_req && bus.mem_gnt_i) begin
      last_owner_d = sel;
    end
`endif

    // The request path is combinational, so reset must mask it explicitly.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_be       = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      instr_gnt    = 1'b0;
      data_gnt     = 1'b0;
      instr_rvalid = 1'b0;
      data_rvalid  = 1'b0;
      instr_rdata  = '0;
      data_rdata   = '0;
    end
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_we_o       = mem_we;
  assign bus.mem_be_o       = mem_be;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wdata_o    = mem_wdata;
  assign bus.instr_gnt_o    = instr_gnt;
  assign bus.data_gnt_o     = data_gnt;
  assign bus.instr_rvalid_o = instr_rvalid;
  assign bus.data_rvalid_o  = data_rvalid;
  assign bus.instr_rdata_o  = instr_rdata;
  assign bus.data_rdata_o   = data_rdata;
  assign bus.arb_err_o      = arb_err_q & ~rst;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed bench for riscv_mem_arbiter. Inputs change
// 1 time unit after the rising edge; outputs are checked 1 unit later.
// Build with +define+RISCV_MEM_ARB_RR_EN to exercise round-robin mode.
module tb_riscv_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.ADDR_W(32), .DATA_WIDTH(32)) bus ();

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_d;
    idle_inputs();

    // Reset: outputs stay 0 even with live requests and a grant.
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h40;
    bus.mem_gnt_i   = 1'b1;
    #2;
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_data_gnt", bus.data_gnt_o, 0);
    chk("rst_instr_gnt", bus.instr_gnt_o, 0);
    chk("rst_arb_err", bus.arb_err_o, 0);
    cyc();
    idle_inputs();
    rst = 1'b0;
    cyc();

    // Single fetch.
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h100;
    bus.mem_gnt_i    = 1'b1;
    #1;
    chk("fetch_gnt", bus.instr_gnt_o, 1);
    chk("fetch_mem_req", bus.mem_req_o, 1);
    chk("fetch_mem_addr", bus.mem_addr_o, 32'h100);
    chk("fetch_mem_we", bus.mem_we_o, 0);
    chk("fetch_mem_be", bus.mem_be_o, 4'hf);
    chk("fetch_mem_wdata", bus.mem_wdata_o, 0);
    chk("fetch_data_gnt", bus.data_gnt_o, 0);
    cyc();
    bus.instr_req_i  = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hdeadbeef;
    #1;
    chk("fetch_rvalid", bus.instr_rvalid_o, 1);
    chk("fetch_rdata", bus.instr_rdata_o, 32'hdeadbeef);
    chk("fetch_mem_req_wait", bus.mem_req_o, 0);
    chk("fetch_data_rvalid", bus.data_rvalid_o, 0);
    chk("fetch_data_rdata", bus.data_rdata_o, 0);
    cyc();
    idle_inputs();
    #1;
    chk("fetch_rvalid_end", bus.instr_rvalid_o, 0);
    chk("fetch_no_err", bus.arb_err_o, 0);

    // Contention with the grant always high.
    for (int i = 0; i < 4; i++) begin
`ifdef RISCV_MEM_ARB_RR_EN
      exp_d = (i % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      cyc();
      bus.instr_req_i  = 1'b1;
      bus.instr_addr_i = 32'h200;
      bus.data_req_i   = 1'b1;
      bus.data_addr_i  = 32'h3000;
      bus.mem_gnt_i    = 1'b1;
      bus.mem_rvalid_i = 1'b0;
      #1;
      chk($sformatf("cont%0d_data_gnt", i), bus.data_gnt_o, exp_d);
      chk($sformatf("cont%0d_instr_gnt", i), bus.instr_gnt_o, !exp_d);
      chk($sformatf("cont%0d_addr", i), bus.mem_addr_o, exp_d ? 32'h3000 : 32'h200);
      cyc();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = 32'ha0 + i;
      #1;
      chk($sformatf("cont%0d_mem_req_wait", i), bus.mem_req_o, 0);
      chk($sformatf("cont%0d_instr_gnt_wait", i), bus.instr_gnt_o, 0);
      chk($sformatf("cont%0d_data_rvalid", i), bus.data_rvalid_o, exp_d);
      chk($sformatf("cont%0d_instr_rvalid", i), bus.instr_rvalid_o, !exp_d);
    end
    cyc();
    idle_inputs();

    // Delayed grant on a store; a fetch arrives while it waits.
    cyc();
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_addr_i  = 32'h2000;
    bus.data_wdata_i = 32'h12345678;
    bus.data_be_i    = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h300;
      end
      #1;
      chk($sformatf("dly%0d_mem_req", c), bus.mem_req_o, 1);
      chk($sformatf("dly%0d_mem_we", c), bus.mem_we_o, 1);
      chk($sformatf("dly%0d_mem_addr", c), bus.mem_addr_o, 32'h2000);
      chk($sformatf("dly%0d_mem_wdata", c), bus.mem_wdata_o, 32'h12345678);
      chk($sformatf("dly%0d_mem_be", c), bus.mem_be_o, 4'b0011);
      chk($sformatf("dly%0d_data_gnt", c), bus.data_gnt_o, 0);
      chk($sformatf("dly%0d_instr_gnt", c), bus.instr_gnt_o, 0);
      cyc();
    end
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("dly3_data_gnt", bus.data_gnt_o, 1);
    chk("dly3_instr_gnt", bus.instr_gnt_o, 0);
    chk("dly3_mem_addr", bus.mem_addr_o, 32'h2000);
    cyc();
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hcafe;
    #1;
    chk("dly4_instr_gnt", bus.instr_gnt_o, 0);
    chk("dly4_data_rvalid", bus.data_rvalid_o, 1);
    chk("dly4_data_rdata", bus.data_rdata_o, 32'hcafe);
    chk("dly4_instr_rdata", bus.instr_rdata_o, 0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("dly5_instr_gnt", bus.instr_gnt_o, 1);
    chk("dly5_mem_addr", bus.mem_addr_o, 32'h300);
    cyc();
    bus.instr_req_i  = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h77;
    #1;
    chk("dly6_instr_rvalid", bus.instr_rvalid_o, 1);
    cyc();
    idle_inputs();

    // Spurious response in IDLE.
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h55;
    #1;
    chk("spur_instr_rvalid", bus.instr_rvalid_o, 0);
    chk("spur_data_rvalid", bus.data_rvalid_o, 0);
    chk("spur_err_early", bus.arb_err_o, 0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("spur_err_pulse", bus.arb_err_o, 1);
    cyc();
    chk("spur_err_clear", bus.arb_err_o, 0);

    // Reset while waiting for a fetch response.
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h400;
    bus.mem_gnt_i    = 1'b1;
    cyc();
    bus.instr_req_i  = 1'b0;
    bus.data_req_i   = 1'b1;
    bus.data_addr_i  = 32'h500;
    bus.mem_rvalid_i = 1'b1;
    rst = 1'b1;
    #1;
    chk("rstw_mem_req", bus.mem_req_o, 0);
    chk("rstw_data_gnt", bus.data_gnt_o, 0);
    chk("rstw_instr_rvalid", bus.instr_rvalid_o, 0);
    chk("rstw_instr_rdata", bus.instr_rdata_o, 0);
    chk("rstw_arb_err", bus.arb_err_o, 0);
    cyc();
    chk("rstw_hold_err", bus.arb_err_o, 0);
    chk("rstw_hold_mem_req", bus.mem_req_o, 0);
    rst = 1'b0;
    bus.data_req_i = 1'b0;
    bus.mem_gnt_i  = 1'b0;
    #1;
    chk("rstw_late_rvalid", bus.instr_rvalid_o, 0);
    cyc();
    bus.mem_rvalid_i = 1'b0;
    #1;
    chk("rstw_err_pulse", bus.arb_err_o, 1);
    cyc();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h600;
    bus.mem_gnt_i    = 1'b1;
    #1;
    chk("rstw_err_clear", bus.arb_err_o, 0);
    chk("rstw_idle_gnt", bus.instr_gnt_o, 1);
    chk("rstw_idle_addr", bus.mem_addr_o, 32'h600);
    cyc();
    idle_inputs();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
